// File: rtl/mem_bus_arb_pkg.sv
// Shared encodings and constants for the memory bus arbiter.
package mem_bus_arb_pkg;

   localparam int unsigned STARVE_CNT_W   = 4;
   localparam logic        FLUSH          = 1'b1;
   localparam logic        DFF_RST_ENABLE = 1'b1;
   localparam logic [31:0] ZEROWORD       = 32'h0000_0000;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_RESP = 2'd2,
      ARB_DROP = 2'd3
   } arb_state_e;

   typedef enum logic {
      ARB_OWN_IF  = 1'b0,
      ARB_OWN_LSU = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Fairness policy: LSU wins unless IF has waited through STARVE_MAX consecutive LSU wins.
module arb_starve_ctr
   import mem_bus_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req,
   input  logic lsu_req,
   input  logic arb_en,
   output logic if_win_c
);

   localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

   logic [STARVE_CNT_W-1:0] starve_cnt;

   always_comb begin
      if_win_c = if_req & (~lsu_req | (starve_cnt == CNT_MAX));
   end

   // Count LSU wins that left IF waiting; any IF win or uncontested LSU win clears.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n == DFF_RST_ENABLE) begin
         starve_cnt <= '0;
      end else if (arb_en) begin
         if (if_win_c || !if_req) begin
            starve_cnt <= '0;
         end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/mem_bus_arb.sv
// Single-outstanding memory bus arbiter between instruction fetch and the LSU.
module mem_bus_arb
   import mem_bus_arb_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_flush,
   input  logic              if_req,
   input  logic [XLEN-1:0]   if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [XLEN-1:0]   if_rdata,
   input  logic              lsu_req,
   input  logic              lsu_we,
   input  logic [XLEN-1:0]   lsu_addr,
   input  logic [XLEN-1:0]   lsu_wdata,
   input  logic [XLEN/8-1:0] lsu_wstrb,
   output logic              lsu_gnt,
   output logic              load_hand_suc,
   output logic              store_hand_suc,
   output logic [XLEN-1:0]   lsu_rdata,
   output logic              bus_req,
   output logic              bus_we,
   output logic [XLEN-1:0]   bus_addr,
   output logic [XLEN-1:0]   bus_wdata,
   output logic [XLEN/8-1:0] bus_wstrb,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [XLEN-1:0]   bus_rdata
);

   arb_state_e state;
   arb_owner_e owner;
   logic       flush_c;
   logic       start_c;
   logic       if_win_c;

   assign flush_c = (pipe_flush == FLUSH);
   assign start_c = (state == ARB_IDLE) && !flush_c && (if_req || lsu_req);

   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .lsu_req  (lsu_req),
      .arb_en   (start_c),
      .if_win_c (if_win_c)
   );

   // Transaction FSM; the bus request fields are registered here.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n == DFF_RST_ENABLE) begin
         state     <= ARB_IDLE;
         owner     <= ARB_OWN_LSU;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wstrb <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (start_c) begin
                  state   <= ARB_ADDR;
                  bus_req <= 1'b1;
                  if (if_win_c) begin
                     owner     <= ARB_OWN_IF;
                     bus_we    <= 1'b0;
                     bus_addr  <= if_addr;
                     bus_wdata <= '0;
                     bus_wstrb <= '0;
                  end else begin
                     owner     <= ARB_OWN_LSU;
                     bus_we    <= lsu_we;
                     bus_addr  <= lsu_addr;
                     bus_wdata <= lsu_wdata;
                     bus_wstrb <= lsu_wstrb;
                  end
               end
            end
            ARB_ADDR: begin
               // A flush withdraws the request even if the slave grants this cycle.
               if (flush_c) begin
                  state   <= ARB_IDLE;
                  bus_req <= 1'b0;
               end else if (bus_gnt) begin
                  state   <= ARB_RESP;
                  bus_req <= 1'b0;
               end
            end
            ARB_RESP: begin
               if (bus_rvalid) begin
                  state <= ARB_IDLE;
               end else if (flush_c) begin
                  state <= ARB_DROP;
               end
            end
            ARB_DROP: begin
               if (bus_rvalid) begin
                  state <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // Same-cycle grant and completion strobes toward the pipeline.
   always_comb begin
      if_gnt         = 1'b0;
      lsu_gnt        = 1'b0;
      if_rvalid      = 1'b0;
      load_hand_suc  = 1'b0;
      store_hand_suc = 1'b0;
      if (state == ARB_ADDR && bus_gnt && !flush_c) begin
         if_gnt  = (owner == ARB_OWN_IF);
         lsu_gnt = (owner == ARB_OWN_LSU);
      end
      if (state == ARB_RESP && bus_rvalid && !flush_c) begin
         if_rvalid      = (owner == ARB_OWN_IF);
         load_hand_suc  = (owner == ARB_OWN_LSU) && !bus_we;
         store_hand_suc = (owner == ARB_OWN_LSU) && bus_we;
      end
   end

   assign if_rdata  = bus_rdata;
   assign lsu_rdata = bus_rdata;

endmodule

// File: doc/mem_bus_arb.md
# mem_bus_arb

Arbitrates the core's single memory bus between the instruction-fetch requester (IF) and the load/store requester in the MEM stage (LSU). It owns the bus request/grant/response handshake, keeps at most one transaction outstanding, and produces the `load_hand_suc`/`store_hand_suc` completion pulses that let the MEM stage advance. It sits between the IF/MEM stages and the external memory interface, and is driven by the same `pipe_flush` as the pipeline registers.

## Interface
- `XLEN`, 32, data/address width
- `STARVE_MAX`, 4, consecutive LSU grants allowed while IF waits; 1..15
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-high (asserted level 1)
- `pipe_flush`  in  1  pipeline flush
- `if_req`  in  1  fetch request, held until `if_gnt`
- `if_addr`  in  XLEN  fetch address
- `if_gnt`  out  1  fetch accepted by bus, 1-cycle pulse
- `if_rvalid`  out  1  fetch data valid, 1-cycle pulse
- `if_rdata`  out  XLEN  fetch data
- `lsu_req`  in  1  load/store request, held until `lsu_gnt`
- `lsu_we`  in  1  1 = store, 0 = load
- `lsu_addr`  in  XLEN  access address
- `lsu_wdata`  in  XLEN  store data
- `lsu_wstrb`  in  XLEN/8  byte strobes
- `lsu_gnt`  out  1  LSU access accepted, 1-cycle pulse
- `load_hand_suc`  out  1  load data returned, 1-cycle pulse
- `store_hand_suc`  out  1  store acknowledged, 1-cycle pulse
- `lsu_rdata`  out  XLEN  load data
- `bus_req`  out  1  bus request, registered
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`  out  1/XLEN/XLEN/XLEN/8  registered request fields
- `bus_gnt`  in  1  slave accepts request when high with `bus_req`
- `bus_rvalid`  in  1  response valid
- `bus_rdata`  in  XLEN  response data

## Operation
- FSM states: IDLE, ADDR, RESP, DROP. Register `owner` is IF or LSU.
- IDLE: if any request is present and `pipe_flush` is 0, pick a winner, latch its fields into the `bus_*` registers, set `owner`, assert `bus_req`, and go to ADDR.
- Arbitration:
  - LSU wins by default.
  - IF wins when `starve_cnt == STARVE_MAX` and `if_req` is high.
  - `starve_cnt` increments on each LSU win while `if_req` is high, saturating at `STARVE_MAX`.
  - `starve_cnt` clears on any IF win, or on an LSU win while `if_req` is low.
- ADDR: while `bus_gnt` is high, pulse the owner's `*_gnt`, drop `bus_req`, and go to RESP. Fields are held stable until then.
- RESP: on `bus_rvalid`, return to IDLE.
  - If `owner` is IF: `if_rvalid` = 1 and `if_rdata` = `bus_rdata`.
  - If `owner` is LSU: pulse `load_hand_suc` or `store_hand_suc` according to the latched `bus_we`; `lsu_rdata` = `bus_rdata`.
  - Response outputs are combinational from `bus_rvalid` and `bus_rdata` (same cycle).
- Flush:
  - `pipe_flush` in ADDR: drop `bus_req` and go to IDLE. No grant pulse is issued.
  - `pipe_flush` in RESP: go to DROP.
  - DROP waits for `bus_rvalid`, suppresses every response pulse, then returns to IDLE.
  - A store already granted still completes on the bus; only its pulse is suppressed.
  - `pipe_flush` in IDLE blocks a new grant that cycle.
- `pipe_flush` arriving in the same cycle as `bus_rvalid` in RESP: the response is discarded and the next state is IDLE.
- Flush while `bus_gnt` is high in ADDR: the flush has priority; the next state is IDLE and `bus_req` deasserts. The slave must tolerate a withdrawn request.
- `bus_rvalid` outside RESP/DROP is ignored.

## Timing
- Reset values:
  - FSM = IDLE, `owner` = LSU, `starve_cnt` = 0.
  - `bus_req`, `bus_we` = 0; `bus_addr`, `bus_wdata` = 0; `bus_wstrb` = 0.
  - All grant and response pulses = 0.
- Reset asserted mid-transaction abandons it immediately. After reset the bus response is ignored until a new request is issued.
- Latency: request sampled in IDLE at cycle N; `bus_req` high at N+1; grant pulse in the `bus_gnt` cycle; completion pulse in the `bus_rvalid` cycle.
- Minimum turnaround is 3 cycles (N to `rvalid` at N+2), with a new grant at the earliest N+3.
- Pulses last exactly 1 cycle; at most one of `if_rvalid`, `load_hand_suc`, `store_hand_suc` is high per cycle.
- Requesters must hold request fields stable from `*_req` until `*_gnt`.

## Structure
- Shared package/defines:
  - FSM state encodings `ARB_IDLE`, `ARB_ADDR`, `ARB_RESP`, `ARB_DROP`.
  - Owner encodings `ARB_OWN_IF`, `ARB_OWN_LSU`.
  - Existing `FLUSH`, `DFF_RST_ENABLE`, `ZEROWORD`.
- One natural sub-module, `arb_starve_ctr`: the saturating counter plus win decision, kept separate so the fairness policy can be swapped.

## Test plan
- Reset: hold `rst_n` = 1 for 3 cycles, release → all outputs are 0 and the state is IDLE; `bus_rvalid` pulses are ignored.
- Single load: `lsu_req`, `lsu_we` = 0, `lsu_addr` = 0x100, `bus_gnt` = 1 immediately, `rvalid` 1 cycle later with `bus_rdata` = 0xDEADBEEF → `bus_req` 1 cycle later, `lsu_gnt` pulse, `load_hand_suc` pulse with `lsu_rdata` = 0xDEADBEEF.
- Contention/starvation: `if_req` and `lsu_req` held continuously, `STARVE_MAX` = 4 → grant sequence LSU, LSU, LSU, LSU, IF, LSU…
- Flush in ADDR: store request, `bus_gnt` held 0 for 2 cycles, `pipe_flush` pulse → `bus_req` drops next cycle; no `lsu_gnt`, no `store_hand_suc`.
- Flush in RESP: load granted, `pipe_flush` before `bus_rvalid` (`rvalid` 3 cycles later) → `load_hand_suc` stays 0; a new IF request is granted only after `rvalid`.
- Simultaneous events: `pipe_flush` and `bus_rvalid` in the same cycle in RESP → no pulse, next state IDLE; a held `if_req` then gets `bus_req` 2 cycles later (after the flush clears).
